// File: rtl/hawk_rd_pkg.sv
// hawk_rd_pkg
//   Definitions shared by the table-read fetch stage, the page-read manager
//   and the compression manager: request type, entry typedefs, and helpers
//   that map 1-based ATT / list entry IDs to 64B line addresses and to the
//   entry slot inside that line.
package hawk_rd_pkg;

  localparam int LINE_BYTES  = 64;
  localparam int ATT_ENTRY_W = 64;
  localparam int LST_ENTRY_W = 128;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {
    TBL_ATT = 1'b0,
    TBL_TOL = 1'b1
  } tbl_rd_type_e;

  typedef logic [ATT_ENTRY_W-1:0] AttEntry;
  typedef logic [LST_ENTRY_W-1:0] ListEntry;

  // Eight 64-bit ATT entries per line: drop the slot bits, scale to bytes.
  function automatic logic [63:0] att_line_addr(input logic [63:0] base,
                                                input logic [63:0] id);
    logic [63:0] idx;
    idx = id - 64'd1;
    return base + ((idx >> 3) << 6);
  endfunction

  // Four 128-bit list entries per line.
  function automatic logic [63:0] lst_line_addr(input logic [63:0] base,
                                                input logic [63:0] id);
    logic [63:0] idx;
    idx = id - 64'd1;
    return base + ((idx >> 2) << 6);
  endfunction

  function automatic logic [2:0] att_slot(input logic [63:0] id);
    logic [63:0] idx;
    idx = id - 64'd1;
    return idx[2:0];
  endfunction

  function automatic logic [1:0] lst_slot(input logic [63:0] id);
    logic [63:0] idx;
    idx = id - 64'd1;
    return idx[1:0];
  endfunction

endpackage

// File: rtl/hawk_line_buf.sv
// hawk_line_buf
//   Single-entry line buffer (tag + data + valid).
//   clk, rst_n   : clock, async active-low reset
//   fill_en      : load fill_tag / fill_data and mark valid
//   inval        : clear valid; wins over a simultaneous fill
//   lookup_tag   : address compared against the stored tag
//   hit          : valid and tag matches lookup_tag
//   line_data    : stored line
module hawk_line_buf #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] line_data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit       = valid && (tag == lookup_tag);
  assign line_data = data;

endmodule

// File: rtl/hawk_tbl_rd_fetch.sv
// hawk_tbl_rd_fetch
//   Fetches one ATT or TOL entry per request. The entry ID is turned into a
//   64B line address, a single-beat AXI read fetches the line (unless the
//   one-line hit buffer already holds it), and the selected raw entry is
//   returned together with the whole line.
//   req_*  : lookup request (valid/ready, type, ATT id, list id)
//   inval_i: table memory was written, drop the hit buffer
//   rsp_*  : response (valid/ready, type, entries, line, address, error)
//   m_*    : AXI4 read address / read data channels
module hawk_tbl_rd_fetch
  import hawk_rd_pkg::*;
#(
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 512,
  parameter int          ATT_ID_W  = 20,
  parameter int          LST_ID_W  = 20,
  parameter logic [63:0] ATT_BASE  = 64'h0,
  parameter logic [63:0] LIST_BASE = 64'h0,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_type_i,
  input  logic [ATT_ID_W-1:0] req_att_id_i,
  input  logic [LST_ID_W-1:0] req_lst_id_i,
  input  logic                inval_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_type_o,
  output logic [63:0]         rsp_att_entry_o,
  output logic [127:0]        rsp_lst_entry_o,
  output logic [DATA_W-1:0]   rsp_line_o,
  output logic [ADDR_W-1:0]   rsp_addr_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic [3:0]          m_arid_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic                m_rlast_i,
  input  logic                m_rvalid_i,
  output logic                m_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_AR,
    S_R,
    S_RSP
  } state_e;

  state_e            state;
  tbl_rd_type_e      type_q;
  logic              id_zero_q;
  logic [ADDR_W-1:0] line_addr_q;
  logic [2:0]        slot_q;

  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_slot;
  logic              acc_zero;
  logic [DATA_W-1:0] sel_line;
  AttEntry           sel_att;
  ListEntry          sel_lst;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              r_beat;
  logic              r_ok;

  assign m_arid_o = AXI_ID;

  // Address/slot of the incoming request, registered on acceptance.
  always_comb begin
    acc_addr = '0;
    acc_slot = '0;
    acc_zero = 1'b0;
    if (req_type_i == TBL_TOL) begin
      acc_addr = ADDR_W'(lst_line_addr(LIST_BASE, 64'(req_lst_id_i)));
      acc_slot = {1'b0, lst_slot(64'(req_lst_id_i))};
      acc_zero = (req_lst_id_i == '0);
    end else begin
      acc_addr = ADDR_W'(att_line_addr(ATT_BASE, 64'(req_att_id_i)));
      acc_slot = att_slot(64'(req_att_id_i));
      acc_zero = (req_att_id_i == '0);
    end
  end

  // The line being answered comes from AXI in R, otherwise from the buffer.
  always_comb begin
    sel_line = (state == S_R) ? m_rdata_i : buf_data;
    sel_att  = sel_line[{slot_q, 6'b0} +: 64];
    sel_lst  = sel_line[{slot_q[1:0], 7'b0} +: 128];
  end

  assign r_beat = (state == S_R) && m_rvalid_i;
  assign r_ok   = (m_rresp_i == AXI_RESP_OKAY) && m_rlast_i;

  // A bad beat also drops the buffer so a retry goes back to memory.
  hawk_line_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .fill_en    (r_beat && r_ok),
    .fill_tag   (line_addr_q),
    .fill_data  (m_rdata_i),
    .inval      (inval_i || (r_beat && !r_ok)),
    .lookup_tag (line_addr_q),
    .hit        (buf_hit),
    .line_data  (buf_data)
  );

  // Main FSM; req_ready_o rises one cycle after reset release so it is 0
  // while in reset and 1 exactly while waiting in IDLE afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= S_IDLE;
      type_q          <= TBL_ATT;
      id_zero_q       <= 1'b0;
      line_addr_q     <= '0;
      slot_q          <= '0;
      req_ready_o     <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_type_o      <= 1'b0;
      rsp_att_entry_o <= '0;
      rsp_lst_entry_o <= '0;
      rsp_line_o      <= '0;
      rsp_addr_o      <= '0;
      rsp_err_o       <= 1'b0;
      m_araddr_o      <= '0;
      m_arvalid_o     <= 1'b0;
      m_rready_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!req_ready_o) begin
            req_ready_o <= 1'b1;
          end else if (req_valid_i) begin
            req_ready_o <= 1'b0;
            type_q      <= tbl_rd_type_e'(req_type_i);
            id_zero_q   <= acc_zero;
            line_addr_q <= acc_addr;
            slot_q      <= acc_slot;
            state       <= S_CHK;
          end
        end
        S_CHK: begin
          rsp_type_o <= type_q;
          rsp_addr_o <= line_addr_q;
          if (id_zero_q) begin
            rsp_valid_o     <= 1'b1;
            rsp_err_o       <= 1'b1;
            rsp_line_o      <= '0;
            rsp_att_entry_o <= '0;
            rsp_lst_entry_o <= '0;
            state           <= S_RSP;
          end else if (buf_hit && !inval_i) begin
            rsp_valid_o     <= 1'b1;
            rsp_err_o       <= 1'b0;
            rsp_line_o      <= buf_data;
            rsp_att_entry_o <= (type_q == TBL_ATT) ? sel_att : '0;
            rsp_lst_entry_o <= (type_q == TBL_TOL) ? sel_lst : '0;
            state           <= S_RSP;
          end else begin
            m_araddr_o  <= line_addr_q;
            m_arvalid_o <= 1'b1;
            state       <= S_AR;
          end
        end
        S_AR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= S_R;
          end
        end
        S_R: begin
          if (m_rvalid_i) begin
            m_rready_o      <= 1'b0;
            rsp_valid_o     <= 1'b1;
            rsp_err_o       <= !r_ok;
            rsp_line_o      <= m_rdata_i;
            rsp_att_entry_o <= (type_q == TBL_ATT) ? sel_att : '0;
            rsp_lst_entry_o <= (type_q == TBL_TOL) ? sel_lst : '0;
            state           <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_tbl_rd_fetch.sv
// tb_hawk_tbl_rd_fetch
//   Directed bench for hawk_tbl_rd_fetch with a simple AXI read slave whose
//   line contents are a function of the line address. Expected responses
//   are pushed to a scoreboard when a request is driven and popped when the
//   DUT raises rsp_valid_o.
module tb_hawk_tbl_rd_fetch;

  localparam logic [63:0] ATT_BASE  = 64'h1000;
  localparam logic [63:0] LIST_BASE = 64'h8000;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_type_i;
  logic [19:0]  req_att_id_i;
  logic [19:0]  req_lst_id_i;
  logic         inval_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic         rsp_type_o;
  logic [63:0]  rsp_att_entry_o;
  logic [127:0] rsp_lst_entry_o;
  logic [511:0] rsp_line_o;
  logic [63:0]  rsp_addr_o;
  logic         rsp_err_o;
  logic [63:0]  m_araddr_o;
  logic [3:0]   m_arid_o;
  logic         m_arvalid_o;
  logic         m_arready_i;
  logic [511:0] m_rdata_i;
  logic [1:0]   m_rresp_i;
  logic         m_rlast_i;
  logic         m_rvalid_i;
  logic         m_rready_o;

  typedef struct {
    logic         typ;
    logic [63:0]  att;
    logic [127:0] lst;
    logic [511:0] line;
    logic [63:0]  addr;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  hawk_tbl_rd_fetch #(
    .ATT_BASE  (ATT_BASE),
    .LIST_BASE (LIST_BASE)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_type_i      (req_type_i),
    .req_att_id_i    (req_att_id_i),
    .req_lst_id_i    (req_lst_id_i),
    .inval_i         (inval_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_type_o      (rsp_type_o),
    .rsp_att_entry_o (rsp_att_entry_o),
    .rsp_lst_entry_o (rsp_lst_entry_o),
    .rsp_line_o      (rsp_line_o),
    .rsp_addr_o      (rsp_addr_o),
    .rsp_err_o       (rsp_err_o),
    .m_araddr_o      (m_araddr_o),
    .m_arid_o        (m_arid_o),
    .m_arvalid_o     (m_arvalid_o),
    .m_arready_i     (m_arready_i),
    .m_rdata_i       (m_rdata_i),
    .m_rresp_i       (m_rresp_i),
    .m_rlast_i       (m_rlast_i),
    .m_rvalid_i      (m_rvalid_i),
    .m_rready_o      (m_rready_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: each 64-bit word carries its line address and word index.
  function automatic logic [63:0] mem_word(input logic [63:0] addr, input int w);
    return {addr[31:0], 32'h5A00_0000 | 32'(w)};
  endfunction

  function automatic logic [511:0] mem_line(input logic [63:0] addr);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[64*w +: 64] = mem_word(addr, w);
    return l;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the response on the bus.
  task automatic checkOutput();
    exp_t e;
    check("sb_nonempty", 512'(sb_q.size() > 0), 512'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("rsp_valid", 512'(rsp_valid_o), 512'd1);
    check("rsp_err", 512'(rsp_err_o), 512'(e.err));
    check("rsp_type", 512'(rsp_type_o), 512'(e.typ));
    if (!e.err) begin
      check("rsp_addr", 512'(rsp_addr_o), 512'(e.addr));
      check("rsp_line", rsp_line_o, e.line);
      if (e.typ) check("rsp_lst_entry", 512'(rsp_lst_entry_o), 512'(e.lst));
      else       check("rsp_att_entry", 512'(rsp_att_entry_o), 512'(e.att));
    end
  endtask

  // Drives one lookup, plays the AXI slave, and checks the response.
  // Latency counts edges from the accepting edge (which counts as 1).
  task automatic applyStimulus(input logic typ, input int id, input bit exp_ar,
                               input bit exp_err, input logic [1:0] rresp,
                               input int ar_hold);
    exp_t        e;
    logic [63:0] addr;
    logic [63:0] first_addr;
    int          slot;
    int          w;
    int          cyc;
    int          ar_cnt;
    bit          ar_seen;
    bit          stable;
    bit          done;

    if (typ) begin
      addr = LIST_BASE + 64'((id - 1) / 4) * 64;
      slot = (id - 1) % 4;
    end else begin
      addr = ATT_BASE + 64'((id - 1) / 8) * 64;
      slot = (id - 1) % 8;
    end
    e.typ  = typ;
    e.addr = addr;
    e.err  = exp_err;
    e.line = mem_line(addr);
    e.att  = mem_word(addr, slot);
    e.lst  = {mem_word(addr, 2*slot + 1), mem_word(addr, 2*slot)};
    sb_q.push_back(e);

    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_type_i   = typ;
    req_att_id_i = 20'(id);
    req_lst_id_i = 20'(id);
    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    check("req_accept", 512'(req_ready_o), 512'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;

    cyc = 1; ar_cnt = 0; ar_seen = 0; stable = 1; done = 0; first_addr = '0;
    while (!done && cyc < 60) begin
      @(posedge clk_i);
      #1;
      cyc++;
      m_arready_i = 1'b0;
      m_rvalid_i  = 1'b0;
      if (rsp_valid_o) begin
        done = 1;
      end else begin
        if (m_arvalid_o) begin
          if (!ar_seen) first_addr = m_araddr_o;
          else if (m_araddr_o !== first_addr) stable = 0;
          ar_seen = 1;
          if (ar_cnt >= ar_hold) m_arready_i = 1'b1;
          ar_cnt++;
        end
        if (m_rready_o) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = mem_line(addr);
          m_rresp_i  = rresp;
          m_rlast_i  = 1'b1;
        end
      end
    end
    check("rsp_timeout", 512'(done), 512'd1);
    check("ar_issued", 512'(ar_seen), 512'(exp_ar));
    if (exp_ar && ar_seen) begin
      check("araddr", 512'(first_addr), 512'(addr));
      check("araddr_stable", 512'(stable), 512'd1);
    end
    if (!exp_ar) check("hit_latency", 512'(cyc), 512'd2);
    if (done) checkOutput();
    else void'(sb_q.pop_front());

    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    check("rsp_drop", 512'(rsp_valid_o), 512'd0);
  endtask

  initial begin
    int w;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_type_i   = 1'b0;
    req_att_id_i = '0;
    req_lst_id_i = '0;
    inval_i      = 1'b0;
    rsp_ready_i  = 1'b0;
    m_arready_i  = 1'b0;
    m_rdata_i    = '0;
    m_rresp_i    = 2'b00;
    m_rlast_i    = 1'b0;
    m_rvalid_i   = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_req_ready", 512'(req_ready_o), 512'd0);
    check("reset_rsp_valid", 512'(rsp_valid_o), 512'd0);
    check("reset_arvalid", 512'(m_arvalid_o), 512'd0);
    check("reset_rready", 512'(m_rready_o), 512'd0);
    check("reset_line", rsp_line_o, 512'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ATT miss, slot 0
    applyStimulus(1'b0, 1, 1'b1, 1'b0, 2'b00, 0);
    // ATT miss on a new line, then a hit in the same line
    applyStimulus(1'b0, 9, 1'b1, 1'b0, 2'b00, 0);
    applyStimulus(1'b0, 10, 1'b0, 1'b0, 2'b00, 0);
    // TOL miss slot 0, then hit on the top slot
    applyStimulus(1'b1, 5, 1'b1, 1'b0, 2'b00, 0);
    applyStimulus(1'b1, 8, 1'b0, 1'b0, 2'b00, 0);
    // Zero ID: error with no AXI traffic
    applyStimulus(1'b1, 0, 1'b0, 1'b1, 2'b00, 0);
    // SLVERR, then the same line must miss again
    applyStimulus(1'b0, 17, 1'b1, 1'b1, 2'b10, 0);
    applyStimulus(1'b0, 18, 1'b1, 1'b0, 2'b00, 0);
    applyStimulus(1'b0, 19, 1'b0, 1'b0, 2'b00, 0);
    // Invalidate between same-line requests; slow arready
    @(negedge clk_i);
    inval_i = 1'b1;
    @(negedge clk_i);
    inval_i = 1'b0;
    applyStimulus(1'b0, 20, 1'b1, 1'b0, 2'b00, 5);

    // Reset while waiting for read data
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_type_i   = 1'b0;
    req_att_id_i = 20'd25;
    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    w = 0;
    while (!m_rready_o && w < 30) begin
      @(posedge clk_i);
      #1;
      m_arready_i = m_arvalid_o;
      w++;
    end
    m_arready_i = 1'b0;
    check("reach_r_state", 512'(m_rready_o), 512'd1);
    rst_ni = 1'b0;
    #1;
    check("midreset_rready", 512'(m_rready_o), 512'd0);
    check("midreset_arvalid", 512'(m_arvalid_o), 512'd0);
    check("midreset_rsp_valid", 512'(rsp_valid_o), 512'd0);
    check("midreset_req_ready", 512'(req_ready_o), 512'd0);
    check("midreset_line", rsp_line_o, 512'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // Buffer was cleared by reset, so a previously cached line misses
    applyStimulus(1'b0, 9, 1'b1, 1'b0, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
